stage3_fast_q_sched: RTL and testbench



---
 rtl/stage3_fast_q_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_stage3_fast_q_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage3_fast_q_sched.sv
// stage3_fast_q_sched: takes a batch of up to three encoded FAST quote messages,
// serialises them in lane order, and maintains the PID1/MC1/MT1 dictionary and
// the per-block emitted byte count.
`ifndef FAST_MESSAGE_BITS
`define FAST_MESSAGE_BITS 64
`endif

// Per-lane capture register: holds one lane's message, length and headers for
// the duration of a batch so the outputs never depend on the live inputs.
module stage3_fast_q_lane #(
  parameter int FAST_W = 64,
  parameter int LEN_W  = 8,
  parameter int PID_W  = 8,
  parameter int MC_W   = 8,
  parameter int MT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [FAST_W-1:0] msg_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [PID_W-1:0]  pid_i,
  input  logic [MC_W-1:0]   mc_i,
  input  logic [MT_W-1:0]   mt_i,
  output logic [FAST_W-1:0] msg_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [PID_W-1:0]  pid_o,
  output logic [MC_W-1:0]   mc_o,
  output logic [MT_W-1:0]   mt_o
);
  logic [FAST_W-1:0] msg_q;
  logic [LEN_W-1:0]  len_q;
  logic [PID_W-1:0]  pid_q;
  logic [MC_W-1:0]   mc_q;
  logic [MT_W-1:0]   mt_q;

  // Capture on batch acceptance, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q <= '0; len_q <= '0; pid_q <= '0; mc_q <= '0; mt_q <= '0;
    end else if (load_i) begin
      msg_q <= msg_i; len_q <= len_i; pid_q <= pid_i; mc_q <= mc_i; mt_q <= mt_i;
    end
  end

  assign msg_o = msg_q;
  assign len_o = len_q;
  assign pid_o = pid_q;
  assign mc_o  = mc_q;
  assign mt_o  = mt_q;
endmodule

module stage3_fast_q_sched #(
  parameter int FAST_W = `FAST_MESSAGE_BITS,
  parameter int LEN_W  = 8,
  parameter int PID_W  = 8,
  parameter int MC_W   = 8,
  parameter int MT_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mask,
  input  logic [FAST_W-1:0] message_fast_1,
  input  logic [FAST_W-1:0] message_fast_2,
  input  logic [FAST_W-1:0] message_fast_3,
  input  logic [LEN_W-1:0]  message_fast_length_1,
  input  logic [LEN_W-1:0]  message_fast_length_2,
  input  logic [LEN_W-1:0]  message_fast_length_3,
  input  logic [PID_W-1:0]  hdr_pid_1,
  input  logic [PID_W-1:0]  hdr_pid_2,
  input  logic [PID_W-1:0]  hdr_pid_3,
  input  logic [MC_W-1:0]   hdr_mc_1,
  input  logic [MC_W-1:0]   hdr_mc_2,
  input  logic [MC_W-1:0]   hdr_mc_3,
  input  logic [MT_W-1:0]   hdr_mt_1,
  input  logic [MT_W-1:0]   hdr_mt_2,
  input  logic [MT_W-1:0]   hdr_mt_3,
  input  logic              block_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FAST_W-1:0] out_message,
  output logic [LEN_W-1:0]  out_length,
  output logic [1:0]        out_lane,
  output logic              out_last,
  output logic [PID_W-1:0]  field_PID1,
  output logic [MC_W-1:0]   field_MC1,
  output logic [MT_W-1:0]   field_MT1,
  output logic [CNT_W-1:0]  byte_count
);
  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_d;
  logic [2:0]       pend_q, pend_d, mask_q, mask_d;
  logic             clr_pend_q, clr_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [MC_W-1:0]  mc_q, mc_d;
  logic [MT_W-1:0]  mt_q, mt_d;

  // Lane inputs gathered into packed arrays so the capture is a generate loop.
  logic [2:0][FAST_W-1:0] msg_in, msg_c;
  logic [2:0][LEN_W-1:0]  len_in, len_c;
  logic [2:0][PID_W-1:0]  pid_in, pid_c;
  logic [2:0][MC_W-1:0]   mc_in, mc_c;
  logic [2:0][MT_W-1:0]   mt_in, mt_c;

  assign msg_in = {message_fast_3, message_fast_2, message_fast_1};
  assign len_in = {message_fast_length_3, message_fast_length_2, message_fast_length_1};
  assign pid_in = {hdr_pid_3, hdr_pid_2, hdr_pid_1};
  assign mc_in  = {hdr_mc_3, hdr_mc_2, hdr_mc_1};
  assign mt_in  = {hdr_mt_3, hdr_mt_2, hdr_mt_1};

  logic accept, load;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DRAIN) && !rst;
  assign accept    = in_valid && in_ready;
  assign load      = accept && (in_mask != 3'b000);

  genvar g;
  for (g = 0; g < 3; g++) begin : g_lane
    stage3_fast_q_lane #(
      .FAST_W(FAST_W), .LEN_W(LEN_W), .PID_W(PID_W), .MC_W(MC_W), .MT_W(MT_W)
    ) u_lane (
      .clk(clk), .rst(rst), .load_i(load),
      .msg_i(msg_in[g]), .len_i(len_in[g]), .pid_i(pid_in[g]),
      .mc_i(mc_in[g]), .mt_i(mt_in[g]),
      .msg_o(msg_c[g]), .len_o(len_c[g]), .pid_o(pid_c[g]),
      .mc_o(mc_c[g]), .mt_o(mt_c[g])
    );
  end

  // Presented lane is the lowest pending bit; dictionary source is the
  // highest lane of the captured mask.
  logic [2:0] low_bit;
  logic [1:0] sel, top;
  logic       has;
  assign low_bit = pend_q & (~pend_q + 3'd1);
  assign has     = |pend_q;
  assign sel     = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
  assign top     = mask_q[2] ? 2'd2 : (mask_q[1] ? 2'd1 : 2'd0);

  assign out_message = has ? msg_c[sel] : '0;
  assign out_length  = has ? len_c[sel] : '0;
  assign out_lane    = has ? sel + 2'd1 : 2'd0;
  assign out_last    = has && (pend_q == low_bit);

  // Saturating byte counter add of the presented length.
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_sat;
  assign sum     = {1'b0, cnt_q} + {{(CNT_W + 1 - LEN_W){1'b0}}, out_length};
  assign cnt_sat = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  logic hs;
  assign hs = out_valid && out_ready;

  // Next-state: batch capture, drain sequencing, dictionary and counter update.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    mask_d     = mask_q;
    clr_pend_d = clr_pend_q;
    cnt_d      = cnt_q;
    pid_d      = pid_q;
    mc_d       = mc_q;
    mt_d       = mt_q;
    case (state_q)
      IDLE: begin
        clr_pend_d = 1'b0;
        if (block_start) begin
          cnt_d = '0; pid_d = '0; mc_d = '0; mt_d = '0;
        end
        if (load) begin
          pend_d  = in_mask;
          mask_d  = in_mask;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (block_start) clr_pend_d = 1'b1;
        if (hs) begin
          pend_d = pend_q & ~low_bit;
          if (out_last) begin
            state_d    = IDLE;
            clr_pend_d = 1'b0;
            // A block boundary seen during the batch wins over the batch's
            // own dictionary write and byte add.
            if (clr_pend_q || block_start) begin
              cnt_d = '0; pid_d = '0; mc_d = '0; mt_d = '0;
            end else begin
              cnt_d = cnt_sat;
              pid_d = pid_c[top];
              mc_d  = mc_c[top];
              mt_d  = mt_c[top];
            end
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= '0;
      clr_pend_q <= 1'b0;
      cnt_q      <= '0;
      pid_q      <= '0;
      mc_q       <= '0;
      mt_q       <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      clr_pend_q <= clr_pend_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      mc_q       <= mc_d;
      mt_q       <= mt_d;
    end
  end

  assign field_PID1 = pid_q;
  assign field_MC1  = mc_q;
  assign field_MT1  = mt_q;
  assign byte_count = cnt_q;
endmodule

// File: tb/tb_stage3_fast_q_sched.sv
// Directed bench for stage3_fast_q_sched with a scoreboard queue of expected
// output messages and a small reference model of the dictionary and counter.
module tb_stage3_fast_q_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, block_start;
  logic [2:0]  in_mask;
  logic [63:0] message_fast_1, message_fast_2, message_fast_3;
  logic [7:0]  message_fast_length_1, message_fast_length_2, message_fast_length_3;
  logic [7:0]  hdr_pid_1, hdr_pid_2, hdr_pid_3;
  logic [7:0]  hdr_mc_1, hdr_mc_2, hdr_mc_3;
  logic [7:0]  hdr_mt_1, hdr_mt_2, hdr_mt_3;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_message;
  logic [7:0]  out_length;
  logic [1:0]  out_lane;
  logic [7:0]  field_PID1, field_MC1, field_MT1;
  logic [15:0] byte_count;

  always #5 clk = ~clk;

  stage3_fast_q_sched #(
    .FAST_W(64), .LEN_W(8), .PID_W(8), .MC_W(8), .MT_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .message_fast_1(message_fast_1), .message_fast_2(message_fast_2),
    .message_fast_3(message_fast_3),
    .message_fast_length_1(message_fast_length_1),
    .message_fast_length_2(message_fast_length_2),
    .message_fast_length_3(message_fast_length_3),
    .hdr_pid_1(hdr_pid_1), .hdr_pid_2(hdr_pid_2), .hdr_pid_3(hdr_pid_3),
    .hdr_mc_1(hdr_mc_1), .hdr_mc_2(hdr_mc_2), .hdr_mc_3(hdr_mc_3),
    .hdr_mt_1(hdr_mt_1), .hdr_mt_2(hdr_mt_2), .hdr_mt_3(hdr_mt_3),
    .block_start(block_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_message(out_message), .out_length(out_length), .out_lane(out_lane),
    .out_last(out_last), .field_PID1(field_PID1), .field_MC1(field_MC1),
    .field_MT1(field_MT1), .byte_count(byte_count)
  );

  typedef struct {
    logic [1:0]  lane;
    logic [63:0] msg;
    logic [7:0]  len;
    logic        last;
    logic [7:0]  pid, mc, mt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt;
  logic [7:0]  m_pid, m_mc, m_mt;
  bit          m_clr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic model_zero();
    m_cnt = '0; m_pid = '0; m_mc = '0; m_mt = '0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"}, byte_count, m_cnt);
    chk({tag, "_pid"}, field_PID1, m_pid);
    chk({tag, "_mc"},  field_MC1,  m_mc);
    chk({tag, "_mt"},  field_MT1,  m_mt);
  endtask

  // Offer one batch in IDLE, push the expected emissions, then scramble inputs.
  task automatic send(input logic [2:0] mask, input logic [7:0] l1, l2, l3, input bit bs);
    logic [63:0] m[3];
    logic [7:0]  p[3], c[3], t[3], l[3];
    int          top;
    exp_t        e;
    l[0] = l1; l[1] = l2; l[2] = l3;
    for (int i = 0; i < 3; i++) begin
      m[i] = {$urandom, $urandom};
      p[i] = 8'($urandom); c[i] = 8'($urandom); t[i] = 8'($urandom);
    end
    @(negedge clk);
    message_fast_1 = m[0]; message_fast_2 = m[1]; message_fast_3 = m[2];
    message_fast_length_1 = l[0]; message_fast_length_2 = l[1]; message_fast_length_3 = l[2];
    hdr_pid_1 = p[0]; hdr_pid_2 = p[1]; hdr_pid_3 = p[2];
    hdr_mc_1 = c[0]; hdr_mc_2 = c[1]; hdr_mc_3 = c[2];
    hdr_mt_1 = t[0]; hdr_mt_2 = t[1]; hdr_mt_3 = t[2];
    in_valid = 1'b1; in_mask = mask; block_start = bs;
    chk("acc_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mask = 3'b000; block_start = 1'b0;
    message_fast_1 = ~m[0]; message_fast_2 = ~m[1]; message_fast_3 = ~m[2];
    message_fast_length_1 = ~l[0]; message_fast_length_2 = ~l[1]; message_fast_length_3 = ~l[2];
    hdr_pid_1 = ~p[0]; hdr_pid_2 = ~p[1]; hdr_pid_3 = ~p[2];
    hdr_mc_1 = ~c[0]; hdr_mc_2 = ~c[1]; hdr_mc_3 = ~c[2];
    hdr_mt_1 = ~t[0]; hdr_mt_2 = ~t[1]; hdr_mt_3 = ~t[2];
    if (bs) model_zero();
    top = mask[2] ? 2 : (mask[1] ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        e.lane = 2'(i + 1); e.msg = m[i]; e.len = l[i]; e.last = (i == top);
        e.pid = p[top]; e.mc = c[top]; e.mt = t[top];
        q.push_back(e);
      end
    end
  endtask

  // Drain the scoreboard; rdy_pat bit i is out_ready on drain cycle i.
  task automatic drain(input logic [15:0] rdy_pat, input int bs_at);
    exp_t e;
    for (int i = 0; i < 24 && q.size() > 0; i++) begin
      @(negedge clk);
      out_ready   = (i < 16) ? rdy_pat[i] : 1'b1;
      block_start = (i == bs_at);
      if (i == bs_at) m_clr = 1'b1;
      e = q[0];
      chk("out_valid", out_valid, 1);
      chk("out_lane", out_lane, e.lane);
      chk("out_msg", out_message, e.msg);
      chk("out_len", out_length, e.len);
      chk("out_last", out_last, e.last);
      if (out_ready) begin
        void'(q.pop_front());
        if (e.last) begin
          if (m_clr) model_zero();
          else begin
            m_cnt = sat(m_cnt, e.len); m_pid = e.pid; m_mc = e.mc; m_mt = e.mt;
          end
          m_clr = 1'b0;
        end else begin
          m_cnt = sat(m_cnt, e.len);
        end
      end
    end
    chk("drain_done", q.size(), 0);
    @(negedge clk);
    out_ready = 1'b0; block_start = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk_state("post");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mask = 3'b000; block_start = 1'b0; out_ready = 1'b0;
    message_fast_1 = '0; message_fast_2 = '0; message_fast_3 = '0;
    message_fast_length_1 = '0; message_fast_length_2 = '0; message_fast_length_3 = '0;
    hdr_pid_1 = '0; hdr_pid_2 = '0; hdr_pid_3 = '0;
    hdr_mc_1 = '0; hdr_mc_2 = '0; hdr_mc_3 = '0;
    hdr_mt_1 = '0; hdr_mt_2 = '0; hdr_mt_3 = '0;
    model_zero(); m_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_msg", out_message, 0);
    chk_state("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // Full batch, continuous ready: 19+20+22 = 61
    send(3'b111, 8'd19, 8'd20, 8'd22, 1'b0);
    drain(16'hFFFF, -1);
    chk("full_cnt61", byte_count, 16'd61);

    // Sparse batch with stalls; lane 2 must be skipped
    send(3'b101, 8'd5, 8'd7, 8'd9, 1'b0);
    drain(16'h000A, -1);

    // Empty mask: accepted, nothing emitted, state untouched
    @(negedge clk);
    in_valid = 1'b1; in_mask = 3'b000;
    chk("m0_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("m0_valid", out_valid, 0);
    chk("m0_ready2", in_ready, 1);
    chk_state("m0");

    // block_start in IDLE clears next cycle
    @(negedge clk);
    block_start = 1'b1;
    @(negedge clk);
    block_start = 1'b0;
    model_zero();
    chk_state("bs_idle");

    // block_start during DRAIN: all lanes emitted, clear wins at the end
    send(3'b111, 8'd19, 8'd20, 8'd22, 1'b0);
    drain(16'hFFFF, 1);

    // block_start together with a batch: clear then accept
    send(3'b011, 8'd3, 8'd4, 8'd0, 1'b0);
    drain(16'hFFFF, -1);
    send(3'b001, 8'd10, 8'd0, 8'd0, 1'b1);
    drain(16'hFFFF, -1);

    // Saturation: build up 65530 then add 22
    @(negedge clk);
    block_start = 1'b1;
    @(negedge clk);
    block_start = 1'b0;
    model_zero();
    for (int b = 0; b < 85; b++) begin
      send(3'b111, 8'd255, 8'd255, 8'd255, 1'b0);
      drain(16'hFFFF, -1);
    end
    send(3'b011, 8'd255, 8'd250, 8'd0, 1'b0);
    drain(16'hFFFF, -1);
    chk("pre_sat", byte_count, 16'd65530);
    send(3'b001, 8'd22, 8'd0, 8'd0, 1'b0);
    drain(16'hFFFF, -1);
    chk("sat_65535", byte_count, 16'hFFFF);

    // Reset mid-DRAIN after lane 1
    send(3'b111, 8'd1, 8'd2, 8'd3, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    chk("rm_lane1", out_lane, 1);
    @(negedge clk);
    rst = 1'b1;
    chk("rm_lane2", out_lane, 2);
    @(negedge clk);
    chk("rm_valid", out_valid, 0);
    chk("rm_in_ready", in_ready, 0);
    chk("rm_cnt", byte_count, 0);
    chk("rm_pid", field_PID1, 0);
    rst = 1'b0;
    q.delete();
    model_zero();
    @(negedge clk);
    chk("rm_rel_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rm_no_stale", out_valid, 0);
      @(negedge clk);
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
